// File: rtl/wiener_pkg.sv
// Shared types and defaults for the Wiener per-block stats path (load and drain sides).
package wiener_pkg;
  localparam int DATA_WIDTH_DEF    = 8;
  localparam int TOTAL_SAMPLES_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_STATS = 2'd1,
    ST_DRAIN      = 2'd2,
    ST_FRAME_DONE = 2'd3
  } wiener_state_e;
endpackage

// File: rtl/wiener_block_readout_fsm_if.sv
// Pixel output stream of the block readout: valid/ready handshake plus block/frame markers.
interface wiener_block_readout_fsm_if #(parameter int DATA_WIDTH = 8);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] pixel_out;
  logic                  out_start_of_block;
  logic                  out_start_of_frame;
  logic                  out_end_of_frame;
  logic [31:0]           block_idx;

  modport master (
    output out_valid, pixel_out, out_start_of_block, out_start_of_frame,
           out_end_of_frame, block_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid, pixel_out, out_start_of_block, out_start_of_frame,
           out_end_of_frame, block_idx,
    output out_ready
  );
endinterface

// File: rtl/wiener_credit_counter.sv
// Counts blocks whose stats are ready but not yet drained; saturates with a sticky overflow.
module wiener_credit_counter #(
  parameter  int MAX_PENDING = 4,
  localparam int CW          = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          overflow
);
  // overflow survives clr on purpose: only reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (count == CW'(MAX_PENDING)) overflow <= 1'b1;
      else                           count    <= count + CW'(1);
    end else if (dec && !inc) begin
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/wiener_block_readout_fsm.sv
// Drain-side controller: waits for per-block stats credits, then pops each block's pixels
// from the shift-register tail with valid/ready and block/frame markers.
module wiener_block_readout_fsm
  import wiener_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int TOTAL_SAMPLES = TOTAL_SAMPLES_DEF,
  parameter int MAX_PENDING   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_of_frame,
  input  logic                  variance_ready,
  input  logic [31:0]           blocks_per_frame,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  output logic                  shift_en,
  output logic                  shift_reg_rst_n,
  output logic                  overflow_err,
  wiener_block_readout_fsm_if.master out
);
  localparam int SW = $clog2(TOTAL_SAMPLES);
  localparam int CW = $clog2(MAX_PENDING + 1);

  wiener_state_e state, state_nxt;
  logic [SW-1:0] sample_cnt;
  logic [31:0]   block_cnt, bpf_q;
  logic [CW-1:0] credit;
  logic          credit_inc, credit_dec, credit_clr;
  logic          pop, last_sample, last_block;

  assign last_sample = (sample_cnt == SW'(TOTAL_SAMPLES - 1));
  assign last_block  = (block_cnt == bpf_q - 32'd1);
  assign pop         = out.out_valid && out.out_ready;

  wiener_credit_counter #(.MAX_PENDING(MAX_PENDING)) u_credit (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (credit_clr),
    .inc      (credit_inc),
    .dec      (credit_dec),
    .count    (credit),
    .overflow (overflow_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // a block boundary with a credit in hand goes straight into the next block
  always_comb begin
    state_nxt  = state;
    credit_dec = 1'b0;
    case (state)
      ST_IDLE:
        if (start_of_frame)
          state_nxt = (blocks_per_frame == 32'd0) ? ST_FRAME_DONE : ST_WAIT_STATS;
      ST_WAIT_STATS:
        if (credit != '0) begin
          state_nxt  = ST_DRAIN;
          credit_dec = 1'b1;
        end
      ST_DRAIN:
        if (pop && last_sample) begin
          if (last_block)             state_nxt  = ST_FRAME_DONE;
          else if (credit != '0)      credit_dec = 1'b1;
          else                        state_nxt  = ST_WAIT_STATS;
        end
      ST_FRAME_DONE: state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out.out_valid          = (state == ST_DRAIN);
    out.pixel_out          = pixel_in;
    out.out_start_of_block = out.out_valid && (sample_cnt == '0);
    out.out_start_of_frame = out.out_start_of_block && (block_cnt == 32'd0);
    out.out_end_of_frame   = out.out_valid && last_sample && last_block;
    out.block_idx          = block_cnt;
    shift_en               = pop;
    shift_reg_rst_n        = (state != ST_FRAME_DONE);
    credit_inc             = variance_ready && (state == ST_WAIT_STATS || state == ST_DRAIN);
    credit_clr             = (state == ST_FRAME_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      block_cnt  <= '0;
      bpf_q      <= '0;
    end else begin
      if (state == ST_IDLE && start_of_frame) bpf_q <= blocks_per_frame;
      if (state == ST_FRAME_DONE) begin
        sample_cnt <= '0;
        block_cnt  <= '0;
      end else if (pop) begin
        sample_cnt <= last_sample ? '0 : sample_cnt + SW'(1);
        if (last_sample && !last_block) block_cnt <= block_cnt + 32'd1;
      end
    end
  end
endmodule
